// File: rtl/row_packer.sv
// row_packer: packs a stream of WORD_W-bit words LSB-first into ROW_W-bit rows and
// presents each completed row to the row arbiter with a rotating slot code 1..4.
// Counts rows per frame and pulses frame_done at the end of a frame.
// Optional build macro ROW_PACKER_STALL_CNT_EN adds the stall_cycles output, which
// counts FILL cycles with no valid input word.
module row_packer #(
    parameter int unsigned ROW_W  = 2304,
    parameter int unsigned WORD_W = 32,
    parameter int unsigned ROWS_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ROWS_W-1:0] num_rows,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ROW_W-1:0]  row_addr_out,
    output logic [2:0]        control,
    output logic              row_done,
    output logic              frame_done,
    output logic              busy
`ifdef ROW_PACKER_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cycles
`endif
);

    localparam int unsigned WORDS_PER_ROW = ROW_W / WORD_W;
    localparam int unsigned CNT_W = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_ROW - 1);

    typedef enum logic [1:0] {IDLE, FILL, EMIT, DONE} state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_word_cnt;
    logic [ROWS_W-1:0]   r_row_cnt;
    logic [ROWS_W-1:0]   r_num_rows;
    logic [2:0]          r_slot;
    logic [ROW_W-1:0]    r_asm;
    logic [ROW_W-1:0]    r_row;
    logic                r_in_ready;
    logic [2:0]          r_control;
    logic                r_row_done;
    logic                r_frame_done;
    logic                r_busy;

    logic                w_xfer;
    logic [ROW_W-1:0]    w_asm_next;
    logic [ROWS_W-1:0]   w_row_cnt_inc;
    logic [2:0]          w_slot_next;

    // abort acts within its own cycle: it blocks the transfer and masks the slot strobe
    assign in_ready     = r_in_ready & ~abort;
    assign control      = abort ? 3'd0 : r_control;
    assign row_done     = r_row_done & ~abort;
    assign frame_done   = r_frame_done;
    assign busy         = r_busy;
    assign row_addr_out = r_row;

    assign w_xfer        = in_valid & in_ready;
    assign w_row_cnt_inc = r_row_cnt + ROWS_W'(1);
    assign w_slot_next   = (r_slot == 3'd4) ? 3'd1 : r_slot + 3'd1;

    // Assembly register with the incoming word merged at its slot in the row
    always_comb begin
        w_asm_next = r_asm;
        w_asm_next[r_word_cnt * WORD_W +: WORD_W] = in_data;
    end

    // Frame/row FSM; outputs are registered from the next state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_word_cnt   <= '0;
            r_row_cnt    <= '0;
            r_num_rows   <= '0;
            r_slot       <= 3'd1;
            r_asm        <= '0;
            r_row        <= '0;
            r_in_ready   <= 1'b0;
            r_control    <= 3'd0;
            r_row_done   <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_control    <= 3'd0;
            r_row_done   <= 1'b0;
            r_frame_done <= 1'b0;
            if (abort) begin
                r_state    <= IDLE;
                r_word_cnt <= '0;
                r_row_cnt  <= '0;
                r_in_ready <= 1'b0;
                r_busy     <= 1'b0;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        if (start) begin
                            r_num_rows <= num_rows;
                            r_word_cnt <= '0;
                            r_row_cnt  <= '0;
                            r_slot     <= 3'd1;
                            r_busy     <= 1'b1;
                            if (num_rows == '0) begin
                                r_state      <= DONE;
                                r_frame_done <= 1'b1;
                            end else begin
                                r_state    <= FILL;
                                r_in_ready <= 1'b1;
                            end
                        end
                    end
                    FILL: begin
                        if (w_xfer) begin
                            r_asm <= w_asm_next;
                            if (r_word_cnt == LAST_WORD) begin
                                r_row      <= w_asm_next;
                                r_word_cnt <= '0;
                                r_state    <= EMIT;
                                r_in_ready <= 1'b0;
                                r_control  <= r_slot;
                                r_row_done <= 1'b1;
                            end else begin
                                r_word_cnt <= r_word_cnt + CNT_W'(1);
                            end
                        end
                    end
                    EMIT: begin
                        r_row_cnt <= w_row_cnt_inc;
                        r_slot    <= w_slot_next;
                        if (w_row_cnt_inc == r_num_rows) begin
                            r_state      <= DONE;
                            r_frame_done <= 1'b1;
                        end else begin
                            r_state    <= FILL;
                            r_in_ready <= 1'b1;
                        end
                    end
                    DONE: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state    <= IDLE;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef ROW_PACKER_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    assign stall_cycles = r_stall_cnt;

    // Saturating count of FILL cycles without a valid word; cleared by an accepted start
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (r_state == IDLE && start && !abort) begin
            r_stall_cnt <= '0;
        end else if (r_state == FILL && !in_valid && r_stall_cnt != 32'hFFFF_FFFF) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_row_packer.sv
// tb_row_packer: directed bench for row_packer with a row/slot scoreboard.
module tb_row_packer;

    localparam int ROW_W  = 2304;
    localparam int WORD_W = 32;
    localparam int ROWS_W = 16;
    localparam int WPR    = ROW_W / WORD_W;

    logic              clock;
    logic              reset;
    logic              start;
    logic              abort;
    logic [ROWS_W-1:0] num_rows;
    logic [WORD_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ROW_W-1:0]  row_addr_out;
    logic [2:0]        control;
    logic              row_done;
    logic              frame_done;
    logic              busy;
`ifdef ROW_PACKER_STALL_CNT_EN
    logic [31:0]       stall_cycles;
`endif

    row_packer #(.ROW_W(ROW_W), .WORD_W(WORD_W), .ROWS_W(ROWS_W)) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .abort(abort),
        .num_rows(num_rows),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .row_addr_out(row_addr_out),
        .control(control),
        .row_done(row_done),
        .frame_done(frame_done),
        .busy(busy)
`ifdef ROW_PACKER_STALL_CNT_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Scoreboard and reference packing model
    logic [ROW_W-1:0] exp_rows[$];
    logic [2:0]       exp_slots[$];
    logic [ROW_W-1:0] rows_seen[$];
    int               emit_cyc[$];
    int               fd_cyc[$];
    logic [ROW_W-1:0] asm_model;
    logic [ROW_W-1:0] last_model_row;
    int               asm_k;
    logic [2:0]       slot_model;
    int               row_done_cnt;
    int               gap_cnt;
    int               idle_cyc;
    int               start_cyc;
    bit               ready_seen;
    logic [31:0]      word_val;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_row(input string tag, input logic [ROW_W-1:0] obs,
                           input logic [ROW_W-1:0] exp);
        int bad;
        bad = -1;
        for (int i = WPR - 1; i >= 0; i--) begin
            if (obs[i*WORD_W +: WORD_W] !== exp[i*WORD_W +: WORD_W]) bad = i;
        end
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: word %0d got %h expected %h", tag, bad,
                   obs[bad*WORD_W +: WORD_W], exp[bad*WORD_W +: WORD_W]);
        end
    endtask

    function automatic void model_push(input logic [WORD_W-1:0] d);
        asm_model[asm_k*WORD_W +: WORD_W] = d;
        asm_k++;
        if (asm_k == WPR) begin
            exp_rows.push_back(asm_model);
            exp_slots.push_back(slot_model);
            last_model_row = asm_model;
            slot_model = (slot_model == 3'd4) ? 3'd1 : slot_model + 3'd1;
            asm_k = 0;
        end
    endfunction

    // Output monitor: every emit is popped from the scoreboard and compared
    always @(negedge clock) begin
        if (reset) begin
            if (in_ready) ready_seen = 1'b1;
            if (row_done || control != 3'd0) begin
                chk("emit_pair", {62'd0, row_done, control != 3'd0}, 64'd3);
                chk("emit_ready_low", in_ready, 0);
                chk("sb_nonempty", exp_rows.size() != 0, 1);
                if (exp_rows.size() != 0) begin
                    chk("emit_slot", control, exp_slots.pop_front());
                    chk_row("emit_row", row_addr_out, exp_rows.pop_front());
                end
                rows_seen.push_back(row_addr_out);
                emit_cyc.push_back(cyc);
                row_done_cnt++;
            end
            if (frame_done) fd_cyc.push_back(cyc);
        end
    end

    task automatic do_start(input int n);
        @(negedge clock);
        num_rows = ROWS_W'(n);
        start = 1'b1;
        slot_model = 3'd1;
        asm_k = 0;
        @(posedge clock);
        #1;
        start_cyc = cyc;
        start = 1'b0;
    endtask

    // gapmode 0: back-to-back; 1: in_valid pattern 1,0,0 repeating
    task automatic send_words(input int n, input int gapmode);
        int sent = 0;
        int t = 0;
        int ph = 0;
        while (sent < n && t < 20000) begin
            @(negedge clock);
            in_valid = (gapmode == 0) ? 1'b1 : ((ph % 3) == 0);
            in_data = word_val;
            ph++;
            t++;
            if (in_valid && in_ready) begin
                model_push(word_val);
                word_val++;
                sent++;
            end else if (!in_valid && in_ready) begin
                gap_cnt++;
            end
        end
        if (sent < n) chk("send_timeout", sent, n);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 500) begin
            @(negedge clock);
            t++;
        end
        idle_cyc = cyc;
        chk("idle_timeout", busy, 0);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        num_rows = '0;
        in_data = '0;
        in_valid = 1'b0;
        asm_model = '0;
        last_model_row = '0;
        asm_k = 0;
        slot_model = 3'd1;
        row_done_cnt = 0;
        gap_cnt = 0;
        word_val = 32'd0;

        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_control", control, 0);
        chk("rst_row_done", row_done, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_busy", busy, 0);
        chk_row("rst_row", row_addr_out, '0);
`ifdef ROW_PACKER_STALL_CNT_EN
        chk("rst_stall", stall_cycles, 0);
`endif
        reset = 1'b1;
        @(negedge clock);
        chk("idle_busy", busy, 0);

        // Basic frame: 4 rows, word value = index
        emit_cyc.delete();
        fd_cyc.delete();
        rows_seen.delete();
        do_start(4);
        chk("basic_busy", busy, 1);
        send_words(4 * WPR, 0);
        wait_idle();
        chk("basic_rows", row_done_cnt, 4);
        chk("basic_gap1", emit_cyc[1] - emit_cyc[0], 73);
        chk("basic_gap2", emit_cyc[2] - emit_cyc[1], 73);
        chk("basic_gap3", emit_cyc[3] - emit_cyc[2], 73);
        chk("basic_fd", fd_cyc[0], emit_cyc[3] + 1);
        begin
            logic [ROW_W-1:0] r0;
            r0 = rows_seen[0];
            chk("row0_lsw", r0[31:0], 0);
            chk("row0_msw", r0[ROW_W-1 -: WORD_W], 71);
        end

        // Slot wrap: 6 rows
        row_done_cnt = 0;
        fd_cyc.delete();
        do_start(6);
        send_words(6 * WPR, 0);
        wait_idle();
        chk("wrap_rows", row_done_cnt, 6);
        chk("wrap_busy_fall", idle_cyc, fd_cyc[0] + 1);
        chk("wrap_sb_empty", exp_rows.size(), 0);

        // Backpressure with in_valid gaps
        row_done_cnt = 0;
        gap_cnt = 0;
        do_start(2);
        send_words(2 * WPR, 1);
        wait_idle();
        chk("bp_rows", row_done_cnt, 2);
        chk("bp_sb_empty", exp_rows.size(), 0);
`ifdef ROW_PACKER_STALL_CNT_EN
        chk("bp_stall", stall_cycles, gap_cnt);
`endif

        // Zero rows
        row_done_cnt = 0;
        fd_cyc.delete();
        ready_seen = 1'b0;
        do_start(0);
        wait_idle();
        repeat (3) @(negedge clock);
        chk("zero_fd", fd_cyc[0], start_cyc);
        chk("zero_fd_cnt", fd_cyc.size(), 1);
        chk("zero_rows", row_done_cnt, 0);
        chk("zero_ready", ready_seen, 0);

        // Abort after 40 words of row 2
        row_done_cnt = 0;
        do_start(3);
        send_words(2 * WPR + 40, 0);
        abort = 1'b1;
        #1;
        chk("abort_ready_gate", in_ready, 0);
        @(posedge clock);
        #1;
        abort = 1'b0;
        @(negedge clock);
        chk("abort_busy", busy, 0);
        chk("abort_ready", in_ready, 0);
        chk("abort_control", control, 0);
        chk_row("abort_row_kept", row_addr_out, last_model_row);
        chk("abort_rows", row_done_cnt, 2);
        chk("abort_sb_empty", exp_rows.size(), 0);
        row_done_cnt = 0;
        do_start(1);
        send_words(WPR, 0);
        wait_idle();
        chk("resume_rows", row_done_cnt, 1);

        // Asynchronous reset while the third row is being emitted
        do_start(4);
        send_words(3 * WPR, 0);
        #1;
        chk("pre_reset_ctrl", control, 3);
        reset = 1'b0;
        #1;
        chk("areset_control", control, 0);
        chk("areset_busy", busy, 0);
        chk_row("areset_row", row_addr_out, '0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        exp_rows.delete();
        exp_slots.delete();
        row_done_cnt = 0;
        fd_cyc.delete();
        do_start(1);
        send_words(WPR, 0);
        wait_idle();
        chk("post_reset_rows", row_done_cnt, 1);
        chk("post_reset_fd", fd_cyc.size(), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
